// File: rtl/cache_line_fill.sv
// Critical-word-first cache line fill sequencer: issues WORDS word reads to a
// pipelined downstream port and streams the returned data into the line buffer.
module cache_line_fill #(
    parameter  int WORDS = 4,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic                i_hclk,
    input  logic                i_hnreset,
    input  logic                i_req,
    input  logic [29-IDX_W:0]   i_line_addr,
    input  logic [IDX_W-1:0]    i_word_offset,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_crit_valid,
    output logic                o_sel,
    output logic [29:0]         o_addr,
    input  logic                i_ready,
    input  logic [31:0]         i_rdata,
    output logic                o_wr_en,
    output logic [IDX_W-1:0]    o_wr_idx,
    output logic [31:0]         o_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STREAM,
        LAST,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t              state, state_d;
    logic [29-IDX_W:0]   line_q, line_d;
    logic [IDX_W-1:0]    off_q, off_d;
    logic [IDX_W-1:0]    acnt, acnt_d;
    logic [IDX_W-1:0]    dcnt, dcnt_d;
    logic [IDX_W-1:0]    issue_idx;

    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            state  <= IDLE;
            line_q <= '0;
            off_q  <= '0;
            acnt   <= '0;
            dcnt   <= '0;
        end else begin
            state  <= state_d;
            line_q <= line_d;
            off_q  <= off_d;
            acnt   <= acnt_d;
            dcnt   <= dcnt_d;
        end
    end

    // Address phase runs one beat ahead of the data phase, so in STREAM each
    // ready cycle both retires data for the previous address and accepts the next.
    always_comb begin
        state_d = state;
        line_d  = line_q;
        off_d   = off_q;
        acnt_d  = acnt;
        dcnt_d  = dcnt;
        o_sel   = 1'b0;
        o_wr_en = 1'b0;
        o_done  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req) begin
                    line_d  = i_line_addr;
                    off_d   = i_word_offset;
                    acnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                o_sel = 1'b1;
                if (i_ready) begin
                    acnt_d  = acnt + ONE;
                    state_d = (WORDS > 1) ? STREAM : LAST;
                end
            end
            STREAM: begin
                o_sel   = 1'b1;
                o_wr_en = i_ready;
                if (i_ready) begin
                    acnt_d = acnt + ONE;
                    dcnt_d = dcnt + ONE;
                    if (acnt == LAST_IDX) state_d = LAST;
                end
            end
            LAST: begin
                o_wr_en = i_ready;
                if (i_ready) begin
                    dcnt_d  = dcnt + ONE;
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Index arithmetic wraps naturally at IDX_W bits, giving the wrap-around order.
    assign issue_idx    = off_q + acnt;
    assign o_addr       = {line_q, issue_idx};
    assign o_wr_idx     = off_q + dcnt;
    assign o_wr_data    = i_rdata;
    assign o_crit_valid = o_wr_en && (dcnt == '0);
    assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench: two DUTs (WORDS=4 and WORDS=16) driven by directed and
// random fills; a memory-like slave returns hash(addr) one beat after acceptance.
module tb_cache_line_fill;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic fin [2];

    function automatic logic [31:0] h(input logic [29:0] a);
        return {a[15:0] ^ 16'h5a5a, a[29:14]} ^ 32'h9e37_79b9;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W  = (g == 0) ? 4 : 16;
        localparam int IW = $clog2(W);
        localparam int LW = 30 - IW;

        logic          rst_n = 1'b0;
        logic          req = 1'b0;
        logic [LW-1:0] line_addr = '0;
        logic [IW-1:0] off = '0;
        logic          ready = 1'b1;
        logic          busy, done, crit, sel, wr_en;
        logic [29:0]   addr;
        logic [31:0]   rdata, wr_data;
        logic [IW-1:0] wr_idx;
        logic [29:0]   pend = '0;

        logic [29:0] addr_q [$];
        logic [30:0] wr_q   [$];
        int          done_q [$];

        cache_line_fill #(.WORDS(W)) u_dut (
            .i_hclk        (clk),
            .i_hnreset     (rst_n),
            .i_req         (req),
            .i_line_addr   (line_addr),
            .i_word_offset (off),
            .o_busy        (busy),
            .o_done        (done),
            .o_crit_valid  (crit),
            .o_sel         (sel),
            .o_addr        (addr),
            .i_ready       (ready),
            .i_rdata       (rdata),
            .o_wr_en       (wr_en),
            .o_wr_idx      (wr_idx),
            .o_wr_data     (wr_data)
        );

        // Downstream slave: data phase returns the word for the last accepted address.
        always @(posedge clk) if (sel && ready) pend <= addr;
        assign rdata = h(pend);

        task automatic push_fill(input logic [LW-1:0] la, input logic [IW-1:0] o, input int exp_done);
            for (int k = 0; k < W; k++) begin
                logic [29:0] a;
                a = {la, IW'(int'(o) + k)};
                addr_q.push_back(a);
                wr_q.push_back({(k == 0), a});
            end
            done_q.push_back(exp_done);
        endtask

        // mode 0: ready held 1, 1: random ready/req noise, 2: 3-cycle stall in STREAM,
        // 3: req held high while busy and in DONE.
        task automatic do_fill(input logic [LW-1:0] la, input logic [IW-1:0] o, input int mode);
            int n;
            int t;
            @(posedge clk); #1;
            n = cyc;
            req = 1'b1; line_addr = la; off = o; ready = 1'b1;
            @(posedge clk); #1;
            push_fill(la, o, (mode == 1) ? -1 : n + W + 2 + ((mode == 2) ? 3 : 0));
            for (t = 1; t < 300 && done_q.size() != 0; t++) begin
                req   = (mode == 3) || (mode == 1 && $urandom_range(0, 1) == 1);
                ready = (mode == 2) ? !(cyc >= n + 2 && cyc <= n + 4)
                      : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                line_addr = LW'($urandom);
                off       = IW'($urandom);
                @(posedge clk); #1;
            end
            req = 1'b0; ready = 1'b1;
            checks++;
            if (done_q.size() != 0 || addr_q.size() != 0 || wr_q.size() != 0) begin
                errors++;
                $display("FAIL W%0d fill_complete: left addr=%0d wr=%0d done=%0d, required all 0",
                         W, addr_q.size(), wr_q.size(), done_q.size());
                addr_q.delete(); wr_q.delete(); done_q.delete();
            end
        endtask

        task automatic reset_mid();
            @(posedge clk); #1;
            req = 1'b1; line_addr = LW'($urandom); off = IW'(1); ready = 1'b1;
            @(posedge clk); #1;
            push_fill(line_addr, off, -1);
            req = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (busy || done || crit || sel || wr_en || addr != '0 || wr_idx != '0) begin
                errors++;
                $display("FAIL W%0d async_reset: busy=%b done=%b crit=%b sel=%b wr_en=%b addr=%h idx=%0d, required all 0",
                         W, busy, done, crit, sel, wr_en, addr, wr_idx);
            end
            checks++;
            if (wr_q.size() != W - 2) begin
                errors++;
                $display("FAIL W%0d writes_before_reset: remaining %0d, required %0d", W, wr_q.size(), W - 2);
            end
            addr_q.delete(); wr_q.delete(); done_q.delete();
            @(posedge clk); #1 rst_n = 1'b1;
        endtask

        always @(negedge clk) begin
            if (!rst_n) begin
                checks++;
                if (busy || done || crit || sel || wr_en || addr != '0 || wr_idx != '0) begin
                    errors++;
                    $display("FAIL W%0d reset_outputs: busy=%b done=%b sel=%b wr_en=%b addr=%h, required all 0",
                             W, busy, done, sel, wr_en, addr);
                end
            end else begin
                checks++;
                if (busy !== (done_q.size() != 0)) begin
                    errors++;
                    $display("FAIL W%0d busy: got %b required %b at cycle %0d", W, busy, done_q.size() != 0, cyc);
                end
                checks++;
                if (sel !== (addr_q.size() != 0)) begin
                    errors++;
                    $display("FAIL W%0d sel: got %b required %b at cycle %0d", W, sel, addr_q.size() != 0, cyc);
                end
                if (sel && addr_q.size() != 0) begin
                    checks++;
                    if (addr !== addr_q[0]) begin
                        errors++;
                        $display("FAIL W%0d addr: got %h required %h at cycle %0d", W, addr, addr_q[0], cyc);
                    end
                    if (ready) void'(addr_q.pop_front());
                end
                checks++;
                if (wr_en !== (ready && wr_q.size() > addr_q.size() + (sel && ready ? 1 : 0))) begin
                    errors++;
                    $display("FAIL W%0d wr_en: got %b ready=%b at cycle %0d", W, wr_en, ready, cyc);
                end
                if (wr_en && wr_q.size() != 0) begin
                    logic [30:0] e;
                    e = wr_q.pop_front();
                    checks++;
                    if (wr_idx !== e[IW-1:0] || crit !== e[30] || wr_data !== h(e[29:0])) begin
                        errors++;
                        $display("FAIL W%0d write: idx=%0d crit=%b data=%h required idx=%0d crit=%b data=%h",
                                 W, wr_idx, crit, wr_data, e[IW-1:0], e[30], h(e[29:0]));
                    end
                end else if (crit) begin
                    checks++; errors++;
                    $display("FAIL W%0d crit_valid: got 1 without a write at cycle %0d", W, cyc);
                end
                if (done) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL W%0d done: unexpected pulse at cycle %0d", W, cyc);
                    end else begin
                        int ed;
                        ed = done_q.pop_front();
                        if (ed >= 0 && ed != cyc) begin
                            errors++;
                            $display("FAIL W%0d done_latency: got cycle %0d required %0d", W, cyc, ed);
                        end
                    end
                end
            end
        end

        initial begin
            fin[g] = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            do_fill(LW'(32'h100), IW'(0), 0);
            do_fill(LW'(32'h100), IW'(2), 0);
            do_fill(LW'($urandom), IW'(W - 1), 0);
            do_fill(LW'($urandom), IW'(1), 2);
            do_fill(LW'($urandom), IW'(3), 3);
            reset_mid();
            do_fill(LW'($urandom), IW'(2), 0);
            repeat (30) do_fill(LW'($urandom), IW'($urandom), 1);
            fin[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 60000 && !(fin[0] === 1'b1 && fin[1] === 1'b1); c++) @(posedge clk);
        checks++;
        if (!(fin[0] === 1'b1 && fin[1] === 1'b1)) begin
            errors++;
            $display("FAIL watchdog: stimulus not finished, fin=%b%b required 11", fin[1], fin[0]);
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
